freq_lock_det: RTL and testbench
================================

FREQ_LOCK_DET -- requirements
Module: freq_lock_det

Interface
REQ-001 SHALL have parameter GATE_W, default 16, width of the gate-length counter.
REQ-002 SHALL have parameter CNT_W, default 12, width of the edge counter and the Target/Tol/Count ports.
REQ-003 SHALL have parameter LOCK_N, default 4, number of consecutive in-tolerance windows required for lock (1..15).
REQ-004 SHALL have port Clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port Fdiv  input  1  divided feedback clock (the divider's PFD-reference output); asynchronous to Clk.
REQ-007 SHALL have port Start  input  1  level enable; high runs back-to-back measurement windows.
REQ-008 SHALL have port GateLen  input  GATE_W  window length in Clk cycles.
REQ-009 SHALL have port Target  input  CNT_W  expected Fdiv rising edges per window.
REQ-010 SHALL have port Tol  input  CNT_W  allowed absolute deviation from Target.
REQ-011 SHALL have port Count  output  CNT_W  registered edge count of the last completed window.
REQ-012 SHALL have port Valid  output  1  one-cycle pulse when Count updates.
REQ-013 SHALL have port Lock  output  1  registered frequency-lock flag.

Function
REQ-014 SHALL pass Fdiv through a 2-flop synchronizer plus one history flop; an edge is counted when synced=1 and history=0 (input-to-detect latency 3 Clk cycles).
REQ-015 SHALL implement a 3-state FSM: IDLE, MEASURE, EVAL.
REQ-016 IDLE: edge counter held at 0; on Start=1 SHALL capture GateLen, Target, Tol and enter MEASURE next cycle.
REQ-017 GateLen=0 SHALL be treated as 1.
REQ-018 MEASURE SHALL last exactly the captured GateLen cycles; each detected edge in those cycles, including the last, increments the edge counter.
REQ-019 Edge counter SHALL saturate at 2^CNT_W-1, no wrap.
REQ-020 After the last MEASURE cycle, FSM SHALL enter EVAL for exactly one cycle; on that cycle's closing edge Count is loaded and Valid=1 for that one cycle.
REQ-021 Edges detected during the EVAL cycle SHALL be discarded (one-cycle dead time per window).
REQ-022 In-tolerance SHALL be |edge count - Target| <= Tol, evaluated with CNT_W+1-bit unsigned difference, no overflow.
REQ-023 In-tolerance window SHALL increment a streak counter saturating at LOCK_N; out-of-tolerance SHALL clear streak and Lock in the same cycle Valid asserts.
REQ-024 Lock SHALL assert in the same cycle as the Valid for the window that brings the streak to LOCK_N, and remain high until an out-of-tolerance window, abort, or reset.
REQ-025 From EVAL: Start=1 SHALL re-capture GateLen/Target/Tol and re-enter MEASURE with counter cleared; Start=0 SHALL go to IDLE.
REQ-026 Start=0 during MEASURE SHALL abort to IDLE next cycle: no Valid, Count unchanged, streak and Lock cleared.
REQ-027 GateLen/Target/Tol changes mid-window SHALL have no effect until next capture.
REQ-028 Count and Lock SHALL hold their values in IDLE.

Reset
REQ-029 Reset=1 SHALL asynchronously force FSM=IDLE, synchronizer/history flops, edge counter, gate counter, streak=0, Count=0, Valid=0, Lock=0.
REQ-030 Reset asserted mid-window SHALL discard the partial count; after release the block waits in IDLE for Start=1.

Verification
REQ-031 Fdiv period 8 Clk, GateLen=800, Target=100, Tol=2, Start held -> Valid every 801 cycles, Count in {99,100,101}, Lock=1 at 4th Valid.
REQ-032 After lock, change Fdiv period to 10 Clk -> next complete window Count in {79,80,81}, Lock=0 in that Valid cycle; restore period 8 -> Lock=1 at 4th subsequent Valid.
REQ-033 Fdiv period 4 Clk, GateLen=65535, CNT_W=12 -> Count=4095 (saturated), out of tolerance for Target=100, Lock=0.
REQ-034 Drop Start at cycle 400 of an 800-cycle window while Lock=1 -> no Valid, Count unchanged, Lock=0 next cycle, FSM IDLE.
REQ-035 Assert Reset at cycle 300 of a window -> Count=0, Valid=0, Lock=0 immediately; re-Start yields a full fresh 800-cycle window.
REQ-036 GateLen=0 with Fdiv held low -> Valid every 2 cycles, Count=0.

Source files
------------

// File: rtl/freq_lock_det.sv
// freq_lock_det
// Counts rising edges of a divided feedback clock over a programmable gate
// window. Each completed count is compared against Target +/- Tol, and Lock is
// raised after LOCK_N consecutive windows are within tolerance. With Start held
// high, windows repeat back to back, separated by one evaluation cycle.
module freq_lock_det #(
   parameter int GATE_W = 16,
   parameter int CNT_W  = 12,
   parameter int LOCK_N = 4
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Fdiv,
   input  logic              Start,
   input  logic [GATE_W-1:0] GateLen,
   input  logic [CNT_W-1:0]  Target,
   input  logic [CNT_W-1:0]  Tol,
   output logic [CNT_W-1:0]  Count,
   output logic              Valid,
   output logic              Lock
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MEASURE = 2'd1,
      S_EVAL    = 2'd2
   } state_t;

   // The streak counter is wide enough for the largest allowed LOCK_N (15).
   localparam int                STRK_W   = 4;
   localparam logic [STRK_W-1:0] LOCK_N_C = STRK_W'(LOCK_N);

   // Increment the edge counter and stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + 1'b1;
   endfunction

   // |cnt - tgt| <= tol, using a difference one bit wider than the operands.
   function automatic logic in_tol(input logic [CNT_W-1:0] cnt,
                                   input logic [CNT_W-1:0] tgt,
                                   input logic [CNT_W-1:0] tol);
      logic [CNT_W:0] diff;
      if (cnt >= tgt) begin
         diff = {1'b0, cnt} - {1'b0, tgt};
      end else begin
         diff = {1'b0, tgt} - {1'b0, cnt};
      end
      return diff <= {1'b0, tol};
   endfunction

   // A zero gate length still gives a one-cycle window.
   function automatic logic [GATE_W-1:0] eff_gate(input logic [GATE_W-1:0] len);
      return (len == '0) ? GATE_W'(1) : len;
   endfunction

   logic              sync1_q, sync2_q, hist_q;
   logic              fdiv_rise;

   state_t            state_q, state_d;
   logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
   logic [CNT_W-1:0]  target_q, target_d;
   logic [CNT_W-1:0]  tol_q, tol_d;
   logic [STRK_W-1:0] streak_q, streak_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              valid_q, valid_d;
   logic              lock_q, lock_d;

   // Two-flop synchronizer for the asynchronous Fdiv, plus a history flop
   // for rising-edge detection.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
      end else begin
         sync1_q <= Fdiv;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   assign fdiv_rise = sync2_q & ~hist_q;

   // State register for the FSM, counters, captured settings and outputs.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         target_q   <= '0;
         tol_q      <= '0;
         streak_q   <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         lock_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         target_q   <= target_d;
         tol_q      <= tol_d;
         streak_q   <= streak_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         lock_q     <= lock_d;
      end
   end

   // Next-state logic. The gate counter counts down the remaining MEASURE
   // cycles and is reloaded at every capture. Valid, Count and Lock are all
   // loaded on the closing edge of EVAL, so they change together.
   always_comb begin
      state_d    = state_q;
      gate_cnt_d = gate_cnt_q;
      edge_cnt_d = edge_cnt_q;
      target_d   = target_q;
      tol_d      = tol_q;
      streak_d   = streak_q;
      count_d    = count_q;
      valid_d    = 1'b0;
      lock_d     = lock_q;

      case (state_q)
         S_IDLE: begin
            edge_cnt_d = '0;
            if (Start) begin
               gate_cnt_d = eff_gate(GateLen);
               target_d   = Target;
               tol_d      = Tol;
               state_d    = S_MEASURE;
            end
         end

         S_MEASURE: begin
            if (!Start) begin
               // Abort: drop the partial window and any lock progress.
               state_d    = S_IDLE;
               edge_cnt_d = '0;
               streak_d   = '0;
               lock_d     = 1'b0;
            end else begin
               if (fdiv_rise) begin
                  edge_cnt_d = sat_inc(edge_cnt_q);
               end
               if (gate_cnt_q == GATE_W'(1)) begin
                  state_d = S_EVAL;
               end else begin
                  gate_cnt_d = gate_cnt_q - 1'b1;
               end
            end
         end

         S_EVAL: begin
            // Edges seen during this cycle are dropped (dead time).
            count_d = edge_cnt_q;
            valid_d = 1'b1;
            if (in_tol(edge_cnt_q, target_q, tol_q)) begin
               if (streak_q < LOCK_N_C) begin
                  streak_d = streak_q + 1'b1;
               end
               lock_d = (streak_d == LOCK_N_C);
            end else begin
               streak_d = '0;
               lock_d   = 1'b0;
            end
            edge_cnt_d = '0;
            if (Start) begin
               gate_cnt_d = eff_gate(GateLen);
               target_d   = Target;
               tol_d      = Tol;
               state_d    = S_MEASURE;
            end else begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign Count = count_q;
   assign Valid = valid_q;
   assign Lock  = lock_q;

endmodule

// File: tb/tb_freq_lock_det.sv
// Testbench for freq_lock_det: window scenarios from a table, hand-written
// multi-cycle sequences, and randomized traffic, all continuously compared
// against a cycle-level reference model of the lock detector.
module tb_freq_lock_det;

   localparam int GATE_W = 16;
   localparam int CNT_W  = 12;
   localparam int LOCK_N = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              Clk     = 1'b0;
   logic              Reset   = 1'b1;
   logic              Fdiv    = 1'b0;
   logic              Start   = 1'b0;
   logic [GATE_W-1:0] GateLen = '0;
   logic [CNT_W-1:0]  Target  = '0;
   logic [CNT_W-1:0]  Tol     = '0;
   logic [CNT_W-1:0]  Count;
   logic              Valid;
   logic              Lock;

   int n_cmp  = 0;
   int n_fail = 0;

   int fper  = 8;     // Fdiv period in Clk cycles (<2 means held low)
   bit frand = 1'b0;  // random Fdiv bits instead of a periodic wave

   // reference model state
   int m_rem    = 0;
   int m_edges  = 0;
   int m_tgt    = 0;
   int m_tol    = 0;
   int m_streak = 0;
   bit m_eval   = 1'b0;
   int e_count  = 0;
   bit e_valid  = 1'b0;
   bit e_lock   = 1'b0;
   bit h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

   typedef struct {
      int per;
      int gate;
      int tgt;
      int tol;
      int nwin;
      int lo;
      int hi;
      int lockmask;
   } vec_t;

   freq_lock_det #(.GATE_W(GATE_W), .CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .Fdiv   (Fdiv),
      .Start  (Start),
      .GateLen(GateLen),
      .Target (Target),
      .Tol    (Tol),
      .Count  (Count),
      .Valid  (Valid),
      .Lock   (Lock)
   );

   initial begin
      forever #5 Clk = ~Clk;
   end

   // Fdiv generator, changes 1 time unit after each rising Clk edge
   initial begin : fdiv_drv
      int ph;
      ph = 0;
      forever begin
         @(posedge Clk);
         #1;
         if (frand) begin
            Fdiv = 1'($urandom_range(0, 1));
         end else if (fper < 2) begin
            Fdiv = 1'b0;
            ph   = 0;
         end else begin
            ph   = (ph + 1) % fper;
            Fdiv = (ph < fper / 2);
         end
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", nm, act, lo, hi, $time);
      end
   endtask

   task automatic model_capture();
      m_rem   = (GateLen == '0) ? 1 : int'(GateLen);
      m_edges = 0;
      m_tgt   = int'(Target);
      m_tol   = int'(Tol);
   endtask

   // Reference model: a window is a number of remaining measure cycles, the
   // raw edge tally is kept unbounded and clipped only when reported.
   // An edge is seen in the DUT three samples after Fdiv rises.
   initial begin : ref_model
      bit ed;
      int c, d;
      forever begin
         @(posedge Clk or posedge Reset);
         if (Reset) begin
            m_rem = 0; m_edges = 0; m_streak = 0; m_eval = 1'b0;
            e_count = 0; e_valid = 1'b0; e_lock = 1'b0;
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
         end else begin
            ed = h2 && !h3;
            e_valid = 1'b0;
            if (m_eval) begin
               c = (m_edges > CMAX) ? CMAX : m_edges;
               d = (c > m_tgt) ? c - m_tgt : m_tgt - c;
               e_count = c;
               e_valid = 1'b1;
               if (d <= m_tol) begin
                  m_streak = (m_streak + 1 > LOCK_N) ? LOCK_N : m_streak + 1;
                  e_lock   = (m_streak == LOCK_N);
               end else begin
                  m_streak = 0;
                  e_lock   = 1'b0;
               end
               m_eval = 1'b0;
               if (Start) model_capture();
            end else if (m_rem > 0) begin
               if (!Start) begin
                  m_rem    = 0;
                  m_streak = 0;
                  e_lock   = 1'b0;
               end else begin
                  if (ed) m_edges++;
                  m_rem--;
                  if (m_rem == 0) m_eval = 1'b1;
               end
            end else if (Start) begin
               model_capture();
            end
            h3 = h2;
            h2 = h1;
            h1 = Fdiv;
         end
      end
   end

   // Every cycle, outputs must match the model
   initial begin : monitor
      logic [CNT_W+1:0] act, exp;
      forever begin
         @(negedge Clk);
         act = {Count, Valid, Lock};
         exp = {CNT_W'(e_count), e_valid, e_lock};
         chk("model_cnt_vld_lock", act, exp);
      end
   end

   // Called 1 time unit after a rising edge; leaves Reset low at the same point.
   task automatic pulse_reset();
      Reset = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
   endtask

   task automatic wait_valid(input int bound, output int n, output bit got);
      n   = 0;
      got = 1'b0;
      while (n < bound && !got) begin
         @(negedge Clk);
         n++;
         if (Valid) got = 1'b1;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int eff, n;
      bit got;
      eff = (v.gate == 0) ? 1 : v.gate;
      @(posedge Clk);
      #1;
      Start   = 1'b0;
      fper    = v.per;
      GateLen = GATE_W'(v.gate);
      Target  = CNT_W'(v.tgt);
      Tol     = CNT_W'(v.tol);
      pulse_reset();
      Start = 1'b1;
      for (int w = 0; w < v.nwin; w++) begin
         wait_valid(eff + 10, n, got);
         chk($sformatf("vec%0d_w%0d_valid_seen", idx, w), got, 1);
         if (!got) break;
         chk($sformatf("vec%0d_w%0d_spacing", idx, w), n, (w == 0) ? eff + 3 : eff + 1);
         chk_rng($sformatf("vec%0d_w%0d_count", idx, w), Count, v.lo, v.hi);
         chk($sformatf("vec%0d_w%0d_lock", idx, w), Lock, (v.lockmask >> w) & 1);
      end
      @(posedge Clk);
      #1;
      Start = 1'b0;
   endtask

   initial begin : main
      vec_t vt[5];
      int   n;
      bit   got;
      int   saved;

      //          per  gate   tgt  tol nwin  lo    hi   lockmask
      vt[0] = '{  8,   800,  100,  2,  4,   99,  101,  'b1000 };
      vt[1] = '{ 10,   800,  100,  2,  2,   79,   81,  'b00   };
      vt[2] = '{  4,   100,   25,  1,  4,   25,   26,  'b1000 };
      vt[3] = '{  0,     0,    0,  0,  5,    0,    0,  'b11000};
      vt[4] = '{  4, 20000,  100,  2,  1, 4095, 4095,  'b0    };

      // reset state
      @(negedge Clk);
      chk("rst_count", Count, 0);
      chk("rst_valid", Valid, 0);
      chk("rst_lock", Lock, 0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;

      for (int i = 0; i < 5; i++) run_vec(vt[i], i);

      // lock at period 8, lose it at period 10, regain at period 8
      @(posedge Clk);
      #1;
      Start = 1'b0; fper = 8; GateLen = 16'd800; Target = 12'd100; Tol = 12'd2;
      pulse_reset();
      Start = 1'b1;
      for (int w = 0; w < 4; w++) begin
         wait_valid(810, n, got);
         chk("h1_pre_valid_seen", got, 1);
      end
      chk("h1_locked_p8", Lock, 1);
      fper = 10;
      wait_valid(810, n, got);
      chk("h1_mixed_valid_seen", got, 1);
      wait_valid(810, n, got);
      chk("h1_p10_valid_seen", got, 1);
      chk_rng("h1_p10_count", Count, 79, 81);
      chk("h1_p10_lock", Lock, 0);
      fper = 8;
      for (int w = 0; w < 4; w++) begin
         wait_valid(810, n, got);
         chk("h1_relock_valid_seen", got, 1);
         chk($sformatf("h1_relock_w%0d_lock", w), Lock, (w == 3) ? 1 : 0);
      end

      // drop Start in the middle of a window while locked
      saved = e_count;
      repeat (400) @(posedge Clk);
      #1;
      Start = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      chk("h2_abort_lock", Lock, 0);
      chk("h2_abort_valid", Valid, 0);
      chk("h2_abort_count", Count, saved);
      got = 1'b0;
      repeat (1000) begin
         @(negedge Clk);
         if (Valid) got = 1'b1;
      end
      chk("h2_idle_no_valid", got, 0);
      chk("h2_idle_count", Count, saved);

      // reset in the middle of a window, then a fresh window
      @(posedge Clk);
      #1;
      Start = 1'b1;
      wait_valid(900, n, got);
      chk("h3_first_valid_seen", got, 1);
      repeat (300) @(posedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      chk("h3_async_count", Count, 0);
      chk("h3_async_valid", Valid, 0);
      chk("h3_async_lock", Lock, 0);
      Start = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
      got = 1'b0;
      repeat (20) begin
         @(negedge Clk);
         if (Valid) got = 1'b1;
      end
      chk("h3_wait_no_valid", got, 0);
      @(posedge Clk);
      #1;
      Start = 1'b1;
      wait_valid(900, n, got);
      chk("h3_fresh_valid_seen", got, 1);
      chk("h3_fresh_latency", n, 803);
      chk_rng("h3_fresh_count", Count, 99, 101);

      // leave via EVAL with Start low: Lock and Count hold in IDLE
      @(posedge Clk);
      #1;
      Start = 1'b0; fper = 4; GateLen = 16'd20; Target = 12'd5; Tol = 12'd1;
      pulse_reset();
      Start = 1'b1;
      for (int w = 0; w < 4; w++) begin
         wait_valid(40, n, got);
         chk("h4_valid_seen", got, 1);
      end
      chk("h4_locked", Lock, 1);
      repeat (20) @(posedge Clk);
      #1;
      Start = 1'b0;
      wait_valid(5, n, got);
      chk("h4_last_valid_seen", got, 1);
      chk("h4_last_valid_time", n, 2);
      chk("h4_last_lock", Lock, 1);
      chk("h4_last_count", Count, 5);
      got = 1'b0;
      repeat (30) begin
         @(negedge Clk);
         if (Valid) got = 1'b1;
      end
      chk("h4_idle_no_valid", got, 0);
      chk("h4_idle_lock", Lock, 1);
      chk("h4_idle_count", Count, 5);

      // randomized traffic; mid-window setting changes and stray resets
      frand = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(posedge Clk);
         #1;
         if (Start) Start = ($urandom_range(0, 99) >= 2);
         else       Start = ($urandom_range(0, 99) < 30);
         if ($urandom_range(0, 9) == 0) GateLen = GATE_W'($urandom_range(0, 24));
         if ($urandom_range(0, 9) == 0) Target  = CNT_W'($urandom_range(0, 8));
         if ($urandom_range(0, 9) == 0) Tol     = CNT_W'($urandom_range(0, 3));
         Reset = ($urandom_range(0, 499) == 0);
      end
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      Start = 1'b0;
      frand = 1'b0;
      repeat (5) @(posedge Clk);
      @(negedge Clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
